// File: rtl/pht_scheduler.sv
// Pattern-history table of 2-bit saturating counters shared by fetch lookups and
// execute-side resolutions; resolutions queue in a FIFO and drain in idle slots.
module pht_scheduler #(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request,
  input  logic [IDX_W-1:0] req_idx,
  output logic             req_ready,
  output logic             prediction,
  output logic             pred_valid,
  input  logic             result,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             taken,
  output logic             res_ready,
  output logic             init_done
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [1:0]       counters [ENTRIES];
  logic [IDX_W-1:0] init_ptr;

  logic [IDX_W-1:0] fifo_idx   [QDEPTH];
  logic             fifo_taken [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;

  logic             accept, push, pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       head_cnt, head_new;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // DRAIN decisions look at the post-edge occupancy so the port is stolen only
  // while the FIFO is actually full and returned as soon as it is half empty.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_ptr == IDX_W'(ENTRIES - 1)) state_next = RUN;
      RUN:     if (count_next == CNT_W'(QDEPTH)) state_next = DRAIN;
      DRAIN:   if (count_next <= CNT_W'(QDEPTH / 2)) state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    req_ready = (state == RUN);
    init_done = (state != INIT);
    res_ready = (state != INIT) && (count < CNT_W'(QDEPTH));
    accept    = request && (state == RUN);
    pop       = (count != '0) && (((state == RUN) && !request) || (state == DRAIN));
  end

  always_comb begin
    push       = result && res_ready;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    head_idx   = fifo_idx[rd_ptr];
    head_taken = fifo_taken[rd_ptr];
    head_cnt   = counters[head_idx];
    head_new   = head_cnt;
    if (head_taken) begin
      if (head_cnt != 2'b11) head_new = head_cnt + 2'd1;
    end else begin
      if (head_cnt != 2'b00) head_new = head_cnt - 2'd1;
    end
  end

  // Table contents are deliberately not reset; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) counters[init_ptr] <= 2'b01;
      else if (pop)      counters[head_idx] <= head_new;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= res_idx;
      fifo_taken[wr_ptr] <= taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pred_valid <= 1'b0;
      prediction <= 1'b0;
    end else begin
      if (state == INIT) init_ptr <= init_ptr + IDX_W'(1);
      if (push)          wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)           rd_ptr   <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      pred_valid <= accept;
      prediction <= accept ? counters[req_idx][1] : 1'b0;
    end
  end

endmodule

// File: doc/pht_scheduler.md
# pht_scheduler

Sequencer and arbiter for a shared pattern-history table of 2-bit saturating counters. Fetch-side prediction lookups and execute-side branch resolutions compete for one table port. The block clears the table after reset and serves one access per cycle. Resolutions go into a small FIFO and drain in idle slots; a full FIFO forces drain priority. It replaces per-branch standalone counters in the front end.

## Interface
- IDX_W, 4: table index width; table holds 2^IDX_W counters.
- QDEPTH, 4: resolution FIFO depth, power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- request  in  1  prediction lookup request; qualified by req_ready.
- req_idx  in  IDX_W  lookup index.
- req_ready  out  1  lookup accepted this cycle when request & req_ready.
- prediction  out  1  predicted direction, 1 = taken; valid when pred_valid.
- pred_valid  out  1  one-cycle pulse, one per accepted lookup.
- result  in  1  branch resolved; qualified by res_ready.
- res_idx  in  IDX_W  resolved branch index.
- taken  in  1  resolved outcome, 1 = taken.
- res_ready  out  1  FIFO can accept a resolution this cycle.
- init_done  out  1  table initialisation complete.

## Operation
- Table: 2^IDX_W × 2-bit registers, internal. Exactly one access per cycle: lookup read, update read-modify-write, or init write.
- FSM states:
  - INIT: entered on rst. A pointer walks 0..2^IDX_W-1, writing 2'b01 (weakly not-taken) to one entry per cycle. After the last entry, go to RUN and set init_done.
  - RUN: normal arbitration.
  - DRAIN: entered from RUN when FIFO count = QDEPTH. Pops one entry per cycle with req_ready=0. Returns to RUN when count ≤ QDEPTH/2.
- RUN arbitration:
  - req_ready=1.
  - request=1 wins the port. The FIFO does not pop that cycle.
  - request=0 and FIFO non-empty: pop the head and update.
- Update rule, 2-bit unsigned:
  - taken=1: counter+1, saturating at 3.
  - taken=0: counter−1, saturating at 0.
- Lookup: prediction = counter[1] of the read entry. Lookups never forward queued, not-yet-applied updates. Stale reads are permitted by design.
- FIFO:
  - res_ready = init_done & (count < QDEPTH).
  - Push when result & res_ready.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - Entries are applied in arrival order. Two updates to the same index apply sequentially, each seeing the previous result.
  - Pointers wrap modulo QDEPTH. count is log2(QDEPTH)+1 bits.
- Inputs outside their ready window are ignored: request when req_ready=0, result when res_ready=0.
- Lookup/update same index, same cycle: cannot happen. Only one access is granted per cycle, so no hazard exists.

## Timing
- Reset values: prediction=0, pred_valid=0, req_ready=0, res_ready=0, init_done=0. FIFO empty, FSM=INIT, init pointer=0. Table contents are undefined until INIT writes them.
- rst asserted at any time, including mid-INIT or mid-DRAIN: on the next edge all state returns to reset values. The FIFO is flushed and lost resolutions are not reported. INIT restarts from entry 0.
- INIT length is exactly 2^IDX_W cycles after the first cycle with rst=0. For IDX_W=4, init_done, req_ready and res_ready rise at the 16th edge after rst deasserts.
- Lookup latency is 1 cycle. A lookup accepted at edge N gives pred_valid=1 and prediction for cycle N+1. Back-to-back lookups give back-to-back pulses.
- Update latency:
  - A resolution pushed at edge N can pop at edge N+1 at the earliest.
  - The counter is written at that same edge.
  - A lookup accepted at edge N+2 or later observes it.
- res_ready, req_ready and FSM transitions are registered-state functions. There are no combinational paths from request/result to the ready outputs.

## Test plan
- Reset/init, IDX_W=4:
  - rst for 2 cycles, then release → init_done rises at the 16th edge.
  - Lookup of idx 5 → prediction=0 one cycle later (counter=01).
- Saturation up:
  - 3 resolutions idx 3 taken=1 with request=0, then lookup idx 3 → prediction=1.
  - 2 more taken=1 → counter stays 3.
  - 2 taken=0 → counter=1, lookup → prediction=0.
- Lookup priority:
  - request=1 continuously on idx 0 while pushing 2 resolutions → FIFO holds 2, no pop, pred_valid every cycle.
  - Drop request → both drain in 2 cycles.
- Full/DRAIN, QDEPTH=4:
  - request held high while pushing 4 resolutions → res_ready=0 at count 4.
  - FSM enters DRAIN and req_ready=0 for 2 cycles until count=2.
  - req_ready returns to 1.
- Simultaneous push/pop:
  - count=1 and request=0 while pushing one resolution → count stays 1.
  - Order preserved: idx 7 taken=1 then idx 7 taken=0 → final counter 01.
- Reset mid-DRAIN:
  - Assert rst with count=3 → next edge count=0, res_ready=0, init_done=0.
  - INIT reruns and all entries read back prediction=0.
